// File: rtl/bdb_press_detector.sv
// Debounced pushbutton press detector: two-flop synchronizer, four-state debounce FSM,
// registered press pulse and level. Optional press counter enabled by BDB_PRESS_COUNT_EN.
module bdb_press_detector #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned COUNT_WIDTH     = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   button,
    output logic                   pressPulse,
    output logic                   pressed
`ifdef BDB_PRESS_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] pressCount
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic             sync1;
    logic             sync2;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pulse_nxt;
    logic             pressed_nxt;

    // Metastability guard on the raw button level
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RELEASED;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: a level change must persist DEBOUNCE_CYCLES samples; a glitch restores the old level
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RELEASED: begin
                if (sync2) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!sync2) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!sync2) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (sync2) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from the transition so the registered outputs line up with the state change
    always_comb begin
        pulse_nxt   = 1'b0;
        pressed_nxt = 1'b0;
        if (state == PRESS_WAIT && state_nxt == HELD) begin
            pulse_nxt = 1'b1;
        end
        if (state_nxt == HELD || state_nxt == RELEASE_WAIT) begin
            pressed_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pressPulse <= 1'b0;
            pressed    <= 1'b0;
        end else begin
            pressPulse <= pulse_nxt;
            pressed    <= pressed_nxt;
        end
    end

`ifdef BDB_PRESS_COUNT_EN
    // Free-running press total, wraps silently
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pressCount <= '0;
        end else if (pulse_nxt) begin
            pressCount <= pressCount + COUNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_bdb_press_detector.sv
// Directed self-checking bench for bdb_press_detector (DEBOUNCE_CYCLES=4); the press counter
// checks are active when BDB_PRESS_COUNT_EN is defined.
module tb_bdb_press_detector;

    logic       clock;
    logic       reset;
    logic       button;
    logic       button_w;
    logic       pressPulse;
    logic       pressed;
    logic       pulse_w;
    logic       pressed_w;
`ifdef BDB_PRESS_COUNT_EN
    logic [15:0] pressCount;
    logic [1:0]  count_w;
`endif

    int n_checks;
    int n_fails;

    bdb_press_detector #(.DEBOUNCE_CYCLES(4), .COUNT_WIDTH(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .button     (button),
        .pressPulse (pressPulse),
        .pressed    (pressed)
`ifdef BDB_PRESS_COUNT_EN
        ,
        .pressCount (pressCount)
`endif
    );

    bdb_press_detector #(.DEBOUNCE_CYCLES(4), .COUNT_WIDTH(2)) dut_w (
        .clock      (clock),
        .reset      (reset),
        .button     (button_w),
        .pressPulse (pulse_w),
        .pressed    (pressed_w)
`ifdef BDB_PRESS_COUNT_EN
        ,
        .pressCount (count_w)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_count(input string tag, input int exp);
`ifdef BDB_PRESS_COUNT_EN
        check_eq(tag, 32'(pressCount), 32'(exp));
`endif
    endtask

    // Assert reset between edges, confirm immediate clear, hold for two edges
    task automatic do_reset();
        reset = 1'b0;
        #1;
        check_eq("rst_pulse", 32'(pressPulse), 32'd0);
        check_eq("rst_pressed", 32'(pressed), 32'd0);
        check_count("rst_count", 0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b0;
        button   = 1'b0;
        button_w = 1'b0;
        #2;
        do_reset();

        // Clean press: pulse only after edge 5, level from edge 5
        button = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check_eq($sformatf("clean_pulse_e%0d", k), 32'(pressPulse), 32'(k == 5));
            check_eq($sformatf("clean_pressed_e%0d", k), 32'(pressed), 32'(k >= 5));
            check_count($sformatf("clean_count_e%0d", k), (k >= 5) ? 1 : 0);
        end
        // Clean release: level falls at edge 5, never a pulse
        button = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check_eq($sformatf("rel_pulse_e%0d", k), 32'(pressPulse), 32'd0);
            check_eq($sformatf("rel_pressed_e%0d", k), 32'(pressed), 32'(k < 5));
        end
        check_count("rel_count", 1);

        // Press bounce: high 3, low 1, high 20; final rise at edge 4 so pulse at edge 9
        do_reset();
        for (int k = 0; k < 24; k++) begin
            button = (k != 3);
            tick();
            check_eq($sformatf("bnc_pulse_e%0d", k), 32'(pressPulse), 32'(k == 9));
            check_eq($sformatf("bnc_pressed_e%0d", k), 32'(pressed), 32'(k >= 9));
        end
        check_count("bnc_count", 1);

        // Release bounce: low 2, high 1, low 10; final fall at edge 3 so level drops at edge 8
        for (int k = 0; k < 13; k++) begin
            button = (k == 2);
            tick();
            check_eq($sformatf("rbnc_pulse_e%0d", k), 32'(pressPulse), 32'd0);
            check_eq($sformatf("rbnc_pressed_e%0d", k), 32'(pressed), 32'(k < 8));
        end
        check_count("rbnc_count", 1);

        // Reset while HELD clears level and count without a clock
        button = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check_eq("held_pressed", 32'(pressed), 32'd1);
        check_count("held_count", 2);
        reset = 1'b0;
        #1;
        check_eq("held_rst_pressed", 32'(pressed), 32'd0);
        check_eq("held_rst_pulse", 32'(pressPulse), 32'd0);
        check_count("held_rst_count", 0);
        tick();
        reset = 1'b1;
        button = 1'b0;
        for (int k = 0; k < 8; k++) tick();

        // Reset during PRESS_WAIT (counter=2), released with button still high
        button = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq($sformatf("pw_pulse_e%0d", k), 32'(pressPulse), 32'd0);
        end
        do_reset();
        for (int k = 0; k < 12; k++) begin
            tick();
            check_eq($sformatf("rr_pulse_e%0d", k), 32'(pressPulse), 32'(k == 5));
            check_eq($sformatf("rr_pressed_e%0d", k), 32'(pressed), 32'(k >= 5));
        end
        check_count("rr_count", 1);
        button = 1'b0;
        for (int k = 0; k < 8; k++) tick();

        // Counter wrap on 2-bit instance: 1,2,3,0,1
        for (int p = 0; p < 5; p++) begin
            button_w = 1'b1;
            for (int k = 0; k < 8; k++) begin
                tick();
                check_eq($sformatf("wrap%0d_pulse_e%0d", p, k), 32'(pulse_w), 32'(k == 5));
            end
`ifdef BDB_PRESS_COUNT_EN
            check_eq($sformatf("wrap%0d_count", p), 32'(count_w), 32'((p + 1) % 4));
`endif
            button_w = 1'b0;
            for (int k = 0; k < 8; k++) begin
                tick();
                check_eq($sformatf("wrap%0d_rel_e%0d", p, k), 32'(pulse_w), 32'd0);
            end
            check_eq($sformatf("wrap%0d_pressed", p), 32'(pressed_w), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
